store_write_buffer: RTL
=======================

// Module: store_write_buffer
// PURPOSE
//  Write side of the data-memory path; counterpart of the load read inside the ALU.
//  Accepts store requests (sb/sh/sw/sd) from the execute stage and formats each one as an
//  8-byte-aligned, byte-masked write. Buffers up to DEPTH stores and drains them in order
//  over a valid/ready write port. The sim top binds that port to the pmem_write DPI.
//  Exposes sb_empty so that loads stall until all older stores have drained.
// PARAMETERS
//  DEPTH   2   buffer entries; power of two, >=2
//  AW      64  address width
//  DW      64  data width; fixed at 64, so the mask is DW/8 = 8 bits
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   synchronous reset, active-low
//  st_valid   in   1   store request valid
//  st_ready   out  1   buffer can accept a request
//  st_addr    in   AW  byte address
//  st_data    in   DW  store data, right-justified
//  st_size    in   2   00 byte, 01 half, 10 word, 11 dword
//  mem_wvalid out  1   write request valid
//  mem_wready in   1   memory accepts the write
//  mem_waddr  out  AW  write address, {addr[AW-1:3],3'b0}
//  mem_wdata  out  DW  write data, lane-shifted
//  mem_wmask  out  8   byte enables
//  sb_empty   out  1   no buffered stores
//  st_err     out  1   one-cycle pulse: misaligned store rejected
//  err_addr   out  AW  address of the last rejected store
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - pointers and count clear; all buffered entries are discarded, even mid-drain
//   - mem_wvalid=0, st_ready=1, sb_empty=1, st_err=0, err_addr=0, wdata/waddr/wmask=0
//  Enqueue fires on st_valid & st_ready. st_ready = (count != DEPTH); no full-bypass.
//  Alignment check: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
//   - misaligned fire: not enqueued; next cycle st_err=1 for one cycle; err_addr=st_addr
//  Formatting (off = addr[2:0]):
//   - mask = base << off, where base is 0x01, 0x03, 0x0F or 0xFF
//   - wdata = (st_data & size-mask) << (8*off)
//   - unused lanes are 0
//  Latency: a store enqueued at cycle N presents mem_wvalid=1 at cycle N+1 (registered).
//  Drain fires on mem_wvalid & mem_wready; FIFO order is strict.
//   - while mem_wvalid=1 and mem_wready=0, waddr, wdata and wmask stay stable
//  mem_wvalid = (count != 0); sb_empty = (count == 0).
//   - sb_empty goes 1 the cycle after the last drain.
//  Simultaneous enqueue and drain:
//   - count is unchanged; pointers advance independently and wrap modulo DEPTH
//   - when full, the same-cycle drain does not raise st_ready in that cycle
//  An error fire together with a drain: the drain proceeds and count decrements.
//  count is $clog2(DEPTH)+1 bits wide; it never exceeds DEPTH and never underflows.
// STRUCTURE
//  Shared defines header:
//   - `MEM_SIZE_B/H/W/D encodings
//   - `STB_DEPTH default
//  Sub-module store_align (combinational): {addr[2:0],size,data} -> {wdata,wmask,misaligned}.
//  Top level holds the FIFO storage, read/write pointers, count and the error register.
// TESTING
//  1. sb, addr 0x80000003, data 0x..AB, wready=1
//     -> waddr 0x80000000, wmask 0x08, wdata 0x00000000AB000000, one cycle after the fire.
//  2. sw, addr 0x80000002 (misaligned)
//     -> no mem_wvalid; st_err pulses 1 cycle; err_addr 0x80000002; sb_empty stays 1.
//  3. wready=0; issue sh@0x10 then sd@0x18
//     -> st_ready=0 after 2 fires; release wready
//     -> writes appear in order: mask 0x03 then 0xFF; sb_empty=1 after the 2nd drain.
//  4. Full buffer; enqueue and drain in the same cycle
//     -> count stays DEPTH; order preserved across pointer wrap.
//  5. Reset asserted while mem_wvalid=1 and wready=0
//     -> next cycle mem_wvalid=0, sb_empty=1; the stale entry is never written.
//  6. Random sizes and addresses vs. a byte-array model (scoreboard)
//     -> memory image matches; aligned stores never assert st_err.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// rtl/store_write_buffer_pkg.sv - store size encodings, buffer defaults and lane-mask helpers
package store_write_buffer_pkg;

  // Store size as presented by the execute stage
  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10,
    MEM_SIZE_D = 2'b11
  } mem_size_e;

  localparam int STB_DEPTH = 2;
  localparam int STB_DW    = 64;
  localparam int STB_MW    = STB_DW / 8;

  // Byte-enable pattern of a store placed at lane 0
  function automatic logic [STB_MW-1:0] size_base_mask(input mem_size_e size);
    logic [STB_MW-1:0] m;
    case (size)
      MEM_SIZE_B: m = 8'h01;
      MEM_SIZE_H: m = 8'h03;
      MEM_SIZE_W: m = 8'h0F;
      default:    m = 8'hFF;
    endcase
    return m;
  endfunction

  // A store is misaligned when any address bit below its natural alignment is set
  function automatic logic size_misaligned(input logic [2:0] off, input mem_size_e size);
    logic mis;
    case (size)
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = off[0];
      MEM_SIZE_W: mis = |off[1:0];
      default:    mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - places right-justified store data onto its byte lanes within a dword
module store_align
  import store_write_buffer_pkg::*;
(
  input  logic [2:0]        addr_off,
  input  logic [1:0]        size,
  input  logic [STB_DW-1:0] data,
  output logic [STB_DW-1:0] wdata,
  output logic [STB_MW-1:0] wmask,
  output logic              misaligned
);

  mem_size_e         size_e;
  logic [STB_MW-1:0] base;
  logic [STB_DW-1:0] lane_keep;

  // Trim data to the store size, then shift data and mask by the byte offset
  always_comb begin
    size_e = mem_size_e'(size);
    base   = size_base_mask(size_e);
    for (int i = 0; i < STB_MW; i++) begin
      lane_keep[8*i +: 8] = {8{base[i]}};
    end
    wmask      = base << addr_off;
    wdata      = (data & lane_keep) << {addr_off, 3'b000};
    misaligned = size_misaligned(addr_off, size_e);
  end

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order buffer of formatted stores draining to a valid/ready write port
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH,
  parameter int AW    = 64,
  parameter int DW    = STB_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [AW-1:0]   st_addr,
  input  logic [DW-1:0]   st_data,
  input  logic [1:0]      st_size,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  output logic            sb_empty,
  output logic            st_err,
  output logic [AW-1:0]   err_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             st_err_q, st_err_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;

  // Entries are stored already formatted so the drain side is a plain read
  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [DW/8-1:0]  mask_mem [DEPTH];

  logic [DW-1:0]    fmt_wdata;
  logic [DW/8-1:0]  fmt_wmask;
  logic             fmt_mis;
  logic             fire, enq, err_fire, deq;

  store_align u_align (
    .addr_off   (st_addr[2:0]),
    .size       (st_size),
    .data       (st_data),
    .wdata      (fmt_wdata),
    .wmask      (fmt_wmask),
    .misaligned (fmt_mis)
  );

  assign st_ready   = (count_q != CNT_FULL);
  assign mem_wvalid = (count_q != '0);
  assign sb_empty   = (count_q == '0);
  assign st_err     = st_err_q;
  assign err_addr   = err_addr_q;

  // Head entry is only shown while valid, so a reset or empty buffer presents zeros
  assign mem_waddr  = mem_wvalid ? addr_mem[rd_ptr_q] : '0;
  assign mem_wdata  = mem_wvalid ? data_mem[rd_ptr_q] : '0;
  assign mem_wmask  = mem_wvalid ? mask_mem[rd_ptr_q] : '0;

  // Handshake decode, pointer/count next state and error capture
  always_comb begin
    fire     = st_valid && st_ready;
    enq      = fire && !fmt_mis;
    err_fire = fire && fmt_mis;
    deq      = mem_wvalid && mem_wready;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    st_err_d   = err_fire;
    err_addr_d = err_addr_q;

    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (err_fire) err_addr_d = st_addr;
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      st_err_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      st_err_q   <= st_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Entry storage written at the tail on an accepted aligned store
  always_ff @(posedge clk) begin
    if (rst_n && enq) begin
      addr_mem[wr_ptr_q] <= {st_addr[AW-1:3], 3'b000};
      data_mem[wr_ptr_q] <= fmt_wdata;
      mask_mem[wr_ptr_q] <= fmt_wmask;
    end
  end

endmodule
